// File: rtl/stopwatch_pkg.sv
// Shared widths, limits and wrap helper for the stopwatch time fields.
// The display driver imports TIME_W from here as well.
package stopwatch_pkg;

    localparam int TIME_W = 6;
    localparam logic [TIME_W-1:0] SEC_MAX = 6'd59;
    localparam logic [TIME_W-1:0] MIN_MAX = 6'd59;

    typedef enum logic {
        MODE_RUN    = 1'b0,
        MODE_ADJUST = 1'b1
    } mode_e;

    // Wraps to zero at max; compared against the limit rather than using modulo.
    function automatic logic [TIME_W-1:0] next_wrap(
        input logic [TIME_W-1:0] value,
        input logic [TIME_W-1:0] max
    );
        return (value == max) ? '0 : value + 1'b1;
    endfunction

endpackage

// File: rtl/stopwatch_button_debounce.sv
// Two-flop synchronizer, stability counter and rising-edge press pulse for a raw button.
// A level change is accepted after DEBOUNCE_CYCLES consecutive cycles of disagreement.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             btn_s;
    logic             level;
    logic [CNT_W-1:0] cnt;

    assign btn_s = sync_q[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b00;
            level  <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn};
            press  <= 1'b0;
            if (btn_s != level) begin
                if (cnt == CNT_LAST) begin
                    // Accept the new level; only a release-to-press edge emits a pulse.
                    level <= btn_s;
                    cnt   <= '0;
                    press <= btn_s;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/stopwatch_core.sv
// Minutes/seconds time base: counts on tick_1hz in run mode, bumps the selected
// field on tick_2hz in adjust mode, and toggles pause on each debounced press.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_1hz,
    input  logic              tick_2hz,
    input  logic              pause_btn,
    input  logic              sel,
    input  logic              adj,
    output logic [TIME_W-1:0] min,
    output logic [TIME_W-1:0] sec,
    output logic              paused
);

    logic [1:0] adj_q;
    logic [1:0] sel_q;
    logic       adj_s;
    logic       sel_s;
    logic       press;
    mode_e      mode;

    assign adj_s = adj_q[1];
    assign sel_s = sel_q[1];
    assign mode  = adj_s ? MODE_ADJUST : MODE_RUN;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_pause_debounce (
        .clk  (clk),
        .rst  (rst),
        .btn  (pause_btn),
        .press(press)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            adj_q <= 2'b00;
            sel_q <= 2'b00;
        end else begin
            adj_q <= {adj_q[0], adj};
            sel_q <= {sel_q[0], sel};
        end
    end

    // Ticks read the pre-toggle paused value when a press lands on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            min    <= '0;
            sec    <= '0;
            paused <= 1'b0;
        end else begin
            if (press) begin
                paused <= ~paused;
            end
            if (mode == MODE_ADJUST) begin
                if (tick_2hz) begin
                    if (sel_s) begin
                        sec <= next_wrap(sec, SEC_MAX);
                    end else begin
                        min <= next_wrap(min, MIN_MAX);
                    end
                end
            end else if (tick_1hz && !paused) begin
                sec <= next_wrap(sec, SEC_MAX);
                if (sec == SEC_MAX) begin
                    min <= next_wrap(min, MIN_MAX);
                end
            end
        end
    end

endmodule

// File: doc/stopwatch_core.md
Name: stopwatch_core

Overview:
- Time-keeping source for the stopwatch display path: produces the minutes/seconds values (0..59 each) that the 7-segment display driver consumes.
- Counts on a 1 Hz enable in run mode; increments the selected field on a 2 Hz enable in adjust mode.
- Debounces the pause button internally and toggles a pause state on each press.
- Sits between the clock-divider enables / board buttons and the display driver.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable clk cycles required before a pause_btn level change is accepted (5 ms at 100 MHz).

Ports:
- clk  input  1  master clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- tick_1hz  input  1  one-clk-wide enable pulse, 1 Hz, synchronous to clk.
- tick_2hz  input  1  one-clk-wide enable pulse, 2 Hz, synchronous to clk.
- pause_btn  input  1  raw asynchronous pause push-button, active-high.
- sel  input  1  raw asynchronous switch: 0 = minutes field, 1 = seconds field.
- adj  input  1  raw asynchronous switch: 1 = adjust mode.
- min  output  6  minutes, binary, 0..59.
- sec  output  6  seconds, binary, 0..59.
- paused  output  1  1 while counting is paused.

Behaviour:
- Reset (rst high at a clk edge): min=0, sec=0, paused=0. Synchronizer flops, debounce counter and debounced level are cleared to 0. A reset during a debounce window discards that window.
- Synchronization:
  - adj, sel and pause_btn each pass through a 2-flop synchronizer.
  - Mode decisions use the synchronized adj/sel, so there are 2 cycles of latency from a pin change.
- Pause debounce:
  - The counter increments while the synchronized pause_btn differs from the debounced level, and clears whenever they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced level takes the new value and the counter clears.
  - A debounced 0->1 transition produces a 1-cycle press pulse; 1->0 produces nothing.
  - A press pulse toggles paused on the following edge.
  - Pin-rise to paused-toggle latency is 2 + DEBOUNCE_CYCLES + 1 cycles.
  - Bounces shorter than DEBOUNCE_CYCLES produce no pulse.
- Run mode (adj_s=0):
  - On tick_1hz with paused=0:
    - sec<59: sec+1.
    - sec==59: sec=0 and min+1.
    - min==59 and sec==59: min=0, sec=0 (wrap to 00:00).
  - tick_2hz is ignored.
  - With paused=1, tick_1hz is ignored and values hold.
- Adjust mode (adj_s=1):
  - tick_1hz is ignored.
  - On tick_2hz, the selected field increments, independent of paused:
    - sel_s=0: min = (min==59) ? 0 : min+1; sec unchanged.
    - sel_s=1: sec = (sec==59) ? 0 : sec+1; min unchanged, no carry.
- Simultaneous events:
  - tick_1hz and tick_2hz in the same cycle: only the enable relevant to the current mode acts.
  - A press pulse in the same cycle as a tick: the tick acts on the pre-toggle paused value.
  - adj_s changing on a tick cycle: the mode value registered in that cycle decides.
- Leaving adjust mode: counting resumes from the adjusted values; paused is retained.
- Output rules:
  - min, sec and paused are registered; they update one edge after the qualifying tick or pulse.
  - min and sec never hold values above 59.
  - All arithmetic is 6-bit unsigned; comparisons are against the constant 59, never via modulo.

Decomposition:
- Shared package stopwatch_pkg:
  - TIME_W = 6
  - SEC_MAX = 59
  - MIN_MAX = 59
  - the function next_wrap(value, max), returning 0 at max and value+1 otherwise.
  - The display driver imports the same TIME_W.
- One sub-module: button_debounce (2-flop sync, stability counter, rising-edge pulse; parameter DEBOUNCE_CYCLES). Instantiated once for pause_btn.
- The adj/sel synchronizers stay inline.

Test Plan (DEBOUNCE_CYCLES=4 in the bench):
- Assert rst for 2 cycles with min=12, sec=34 preloaded via adjust -> min=0, sec=0, paused=0 one edge after the first reset edge.
- From reset, run mode: apply 60 tick_1hz pulses -> min=1, sec=0. Preload 59:59, apply 1 tick -> 00:00.
- Adjust, sel=1 from sec=58: apply 3 tick_2hz -> sec=59, 0, 1; min unchanged, no carry. Also apply tick_1hz in this mode -> no change.
- Adjust, sel=0 from min=59: apply 1 tick_2hz -> min=0, sec unchanged. Drop adj after 2 sync cycles, apply tick_1hz -> sec+1.
- pause_btn glitches high for 3 cycles -> paused stays 0. Hold high for 10 cycles -> paused=1 exactly 7 cycles after the pin rise. Subsequent tick_1hz -> values hold. Release and press again -> paused=0.
- Drive tick_1hz and the press pulse in the same cycle with paused=0 -> sec increments once, then paused=1.
